// File: rtl/seq_scan_pkg.sv
// Shared types and the pattern definition for the word-level 01101 scan controller.
// The detector's forward transitions are derived from PATTERN; the fallback edges encode the overlap.
package seq_scan_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] PATTERN = 5'b01101;

    // State Sn means the last n bits seen equal the first n bits of PATTERN.
    function automatic det_state_t det_next(input det_state_t s, input logic x);
        case (s)
            S0:      return (x == PATTERN[4]) ? S1 : S0;
            S1:      return (x == PATTERN[3]) ? S2 : S1;
            S2:      return (x == PATTERN[2]) ? S3 : S1;
            S3:      return (x == PATTERN[1]) ? S4 : S0;
            S4:      return (x == PATTERN[0]) ? S5 : S1;
            S5:      return x ? S3 : S1;
            default: return S0;
        endcase
    endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word-in / count-out handshake bundle for seq_scan_ctrl, plus debug status.
interface seq_scan_ctrl_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(WORD_W + 1)
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              in_restart;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_hit;
    logic              busy;
    logic [2:0]        det_state;

    modport master (
        output in_valid, in_word, in_restart, out_ready,
        input  in_ready, out_valid, out_count, out_hit, busy, det_state
    );

    modport slave (
        input  in_valid, in_word, in_restart, out_ready,
        output in_ready, out_valid, out_count, out_hit, busy, det_state
    );
endinterface

// File: rtl/seq_det_core.sv
// Enable-gated Moore detector for the overlapping pattern 01101; match while in S5.
// clr wins over bit_en so a restart lands in S0 regardless of the current input.
module seq_det_core
    import seq_scan_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       bit_en,
    input  logic       x,
    output det_state_t state,
    output logic       match,
    output logic       next_is_match
);

    det_state_t state_q;
    det_state_t state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S0;
        else       state_q <= state_d;
    end

    // Illegal encodings recover to S0 even while bit_en is low.
    always_comb begin
        state_d = state_q;
        if (clr)
            state_d = S0;
        else if (state_q > S5)
            state_d = S0;
        else if (bit_en)
            state_d = det_next(state_q, x);
    end

    assign state         = state_q;
    assign match         = (state_q == S5);
    assign next_is_match = bit_en && (state_d == S5);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts words, shifts them MSB-first into seq_det_core and reports detections per word.
// Detector state persists across words unless the word arrives with in_restart.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic         clk,
    input  logic         reset,
    seq_scan_ctrl_if.slave bus
);

    ctrl_state_t       cs;
    ctrl_state_t       ns;
    logic [WORD_W-1:0] sreg;
    logic [CNT_W-1:0]  bitcnt;
    logic [CNT_W-1:0]  count;

    logic load;
    logic clr;
    logic bit_en;
    logic in_ready_c;
    logic out_valid_c;
    logic last_bit;

    det_state_t det_st;
    logic       det_match_unused;
    logic       next_is_match;

    seq_det_core u_core (
        .clk           (clk),
        .reset         (reset),
        .clr           (clr),
        .bit_en        (bit_en),
        .x             (sreg[WORD_W-1]),
        .state         (det_st),
        .match         (det_match_unused),
        .next_is_match (next_is_match)
    );

    assign last_bit = (bitcnt == CNT_W'(WORD_W - 1));

    always_ff @(posedge clk) begin
        if (reset) cs <= IDLE;
        else       cs <= ns;
    end

    always_comb begin
        ns          = cs;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        bit_en      = 1'b0;
        clr         = 1'b0;
        load        = 1'b0;
        case (cs)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    load = 1'b1;
                    clr  = bus.in_restart;
                    ns   = SHIFT;
                end
            end
            SHIFT: begin
                bit_en = 1'b1;
                if (last_bit) ns = REPORT;
            end
            REPORT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) ns = IDLE;
            end
            default: ns = IDLE;
        endcase
    end

    // Count is credited on the edge that moves the core into S5, so a match
    // completed by a word's first bits belongs to that word.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg   <= '0;
            bitcnt <= '0;
            count  <= '0;
        end else if (load) begin
            sreg   <= bus.in_word;
            bitcnt <= '0;
            count  <= '0;
        end else if (bit_en) begin
            sreg   <= sreg << 1;
            bitcnt <= bitcnt + 1'b1;
            if (next_is_match) count <= count + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_count = count;
    assign bus.out_hit   = (count != '0);
    assign bus.busy      = (cs != IDLE);
    assign bus.det_state = det_st;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: expected results are queued at issue time and a
// negedge monitor pops and compares them on every output handshake.
module tb_seq_scan_ctrl;
    import seq_scan_pkg::*;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_scan_ctrl_if #(.WORD_W(W), .CNT_W(CW)) bus ();

    seq_scan_ctrl #(.WORD_W(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int cnt;
        int hit;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Scoreboard monitor: every accepted result must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_count", int'(bus.out_count), mon_e.cnt);
                chk("out_hit", int'(bus.out_hit), mon_e.hit);
            end
        end
    end

    task automatic offer(input logic [W-1:0] w, input logic rs);
        bus.in_valid   = 1'b1;
        bus.in_word    = w;
        bus.in_restart = rs;
    endtask

    // Returns at posedge+2 of the accepting edge with in_valid dropped.
    task automatic wait_accept();
        int t = 0;
        bit rdy = 1'b0;
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #2;
            t++;
        end while (!rdy && t < 50);
        chk("accept_timeout", int'(rdy), 1);
        bus.in_valid = 1'b0;
    endtask

    // n0 = negedges already consumed since the accepting edge.
    task automatic wait_result(input int n0);
        int n = n0;
        bit v = 1'b0;
        while (!v && n < 40) begin
            @(negedge clk);
            n++;
            v = bus.out_valid;
        end
        chk("latency", n, W + 1);
    endtask

    task automatic word(input logic [W-1:0] w, input logic rs, input int exp_cnt,
                        input int exp_st, input string name);
        sb.push_back('{exp_cnt, (exp_cnt != 0) ? 1 : 0});
        offer(w, rs);
        wait_accept();
        wait_result(0);
        @(posedge clk); #2;
        @(negedge clk);
        chk({name, "_in_ready"}, int'(bus.in_ready), 1);
        chk({name, "_det_state"}, int'(bus.det_state), exp_st);
        @(posedge clk); #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_word    = '0;
        bus.in_restart = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_det_state", int'(bus.det_state), 0);
        chk("rst_out_count", int'(bus.out_count), 0);
        chk("rst_out_hit", int'(bus.out_hit), 0);
        @(posedge clk); #2;

        word(8'h6D, 1'b1, 2, S5, "overlap");
        word(8'h00, 1'b1, 0, S1, "zeros");
        word(8'hFF, 1'b1, 0, S0, "ones");
        word(8'h03, 1'b1, 0, S3, "x03");
        word(8'h40, 1'b0, 1, S1, "x40_carry");
        word(8'h03, 1'b1, 0, S3, "x03_again");
        word(8'h40, 1'b1, 0, S1, "x40_restart");

        // Backpressure: result held while a new word waits at the input.
        bus.out_ready = 1'b0;
        sb.push_back('{2, 1});
        offer(8'h6D, 1'b1);
        wait_accept();
        wait_result(0);
        @(posedge clk); #2;
        sb.push_back('{0, 0});
        offer(8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_out_count", int'(bus.out_count), 2);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            @(posedge clk); #2;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_at_hs", int'(bus.in_ready), 0);
        @(posedge clk); #2;
        @(negedge clk);
        chk("bp_in_ready_after_hs", int'(bus.in_ready), 1);
        chk("bp_busy_after_hs", int'(bus.busy), 0);
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepted", int'(bus.busy), 1);
        wait_result(1);
        @(posedge clk); #2;
        @(negedge clk);
        chk("bp_det_state", int'(bus.det_state), S1);
        @(posedge clk); #2;

        // Mid-scan reset on the 4th SHIFT cycle: the word is dropped silently.
        offer(8'h6D, 1'b1);
        wait_accept();
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("mrst_busy", int'(bus.busy), 0);
        chk("mrst_det_state", int'(bus.det_state), S0);
        chk("mrst_in_ready", int'(bus.in_ready), 1);
        chk("mrst_out_valid", int'(bus.out_valid), 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        chk("mrst_no_output", int'(seen), 0);
        @(posedge clk); #2;
        word(8'h6D, 1'b0, 2, S5, "post_reset");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
